// File: rtl/arvi_dmem_pkg.sv
// arvi_dmem_pkg: shared FSM state and request types for the data-memory bridge
`ifndef XLEN
`define XLEN 32
`endif
package arvi_dmem_pkg;
  typedef enum logic [1:0] {IDLE, BUS, DONE} state_t;
  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  byte_en;
    logic        wr;
  } req_t;
  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  byte_en;
  } wbuf_t;
endpackage

// File: rtl/arvi_wbuf.sv
// arvi_wbuf: synchronous FIFO for posted stores (push/pop ignored when full/empty)
// Ports: i_clk, i_rst_n, push, pop, din -> dout (head entry), full, empty
module arvi_wbuf import arvi_dmem_pkg::*; #(
  parameter int DEPTH = 2
) (
  input  logic  i_clk,
  input  logic  i_rst_n,
  input  logic  push,
  input  logic  pop,
  input  wbuf_t din,
  output wbuf_t dout,
  output logic  full,
  output logic  empty
);
  localparam int AW = $clog2(DEPTH);
  logic [AW:0] wp, rp;
  wbuf_t mem [DEPTH];
  // Extra pointer MSB tells a full FIFO from an empty one after wrap-around
  assign empty = wp == rp;
  assign full = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
  assign dout = mem[rp[AW-1:0]];
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      wp <= '0;
      rp <= '0;
    end else begin
      wp <= wp + {{AW{1'b0}}, push & ~full};
      rp <= rp + {{AW{1'b0}}, pop & ~empty};
    end
  always_ff @(posedge i_clk)
    if (push && !full) mem[wp[AW-1:0]] <= din;
endmodule

// File: rtl/arvi_dmem_bridge.sv
// arvi_dmem_bridge: core data-memory port to single-transaction system-bus bridge
// Core side: i_DM_MemRead/i_DM_Wen/i_DM_Addr/i_DM_Wd/i_DM_byte_en in, o_DM_data_ready pulse, o_DM_ReadData.
// Bus side: o_bus_en/o_wr_en/o_addr/o_wr_data/o_byte_en out, i_ack/i_rd_data in.
// ARVI_DMEM_WBUF_EN enables a WBUF_DEPTH-entry posted-write buffer.
`ifndef XLEN
`define XLEN 32
`endif
module arvi_dmem_bridge import arvi_dmem_pkg::*; #(
  parameter int WBUF_DEPTH = 2
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_DM_MemRead,
  input  logic             i_DM_Wen,
  input  logic [`XLEN-1:0] i_DM_Addr,
  input  logic [`XLEN-1:0] i_DM_Wd,
  input  logic [3:0]       i_DM_byte_en,
  output logic             o_DM_data_ready,
  output logic [`XLEN-1:0] o_DM_ReadData,
  output logic             o_bus_en,
  output logic             o_wr_en,
  output logic [31:0]      o_addr,
  output logic [31:0]      o_wr_data,
  output logic [3:0]       o_byte_en,
  input  logic             i_ack,
  input  logic [31:0]      i_rd_data
);
  state_t state;
  req_t req, core_req, next_req;
  logic start, start_drain, drain, done_rdy, post_rdy;
  // A store wins when both request lines are high
  assign core_req = '{addr: i_DM_Addr, wdata: i_DM_Wd, byte_en: i_DM_byte_en, wr: i_DM_Wen};
`ifdef ARVI_DMEM_WBUF_EN
  wbuf_t head;
  logic full, empty, push;
  // Stores are posted independently of the bus FSM; post_rdy blocks re-accepting the held request
  assign push = i_DM_Wen & ~full & ~post_rdy;
  assign start_drain = ~empty;
  assign start = start_drain | (i_DM_MemRead & ~i_DM_Wen);
  assign next_req = start_drain ? req_t'{addr: head.addr, wdata: head.wdata, byte_en: head.byte_en, wr: 1'b1} : core_req;
  // Head stays queued while on the bus so a stalled drain still occupies its slot
  arvi_wbuf #(.DEPTH(WBUF_DEPTH)) u_wbuf (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .push    (push),
    .pop     (state == BUS && drain && i_ack),
    .din     (wbuf_t'{addr: i_DM_Addr, wdata: i_DM_Wd, byte_en: i_DM_byte_en}),
    .dout    (head),
    .full    (full),
    .empty   (empty)
  );
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) post_rdy <= 1'b0;
    else post_rdy <= push;
`else
  // Depth only matters with the write buffer
  logic [31:0] depth_unused;
  assign depth_unused = WBUF_DEPTH;
  assign start_drain = 1'b0;
  assign start = i_DM_MemRead | i_DM_Wen;
  assign next_req = core_req;
  assign post_rdy = 1'b0;
`endif
  assign o_addr = req.addr;
  assign o_wr_en = req.wr;
  assign o_wr_data = req.wdata;
  assign o_byte_en = req.byte_en;
  assign o_DM_data_ready = done_rdy | post_rdy;
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      state <= IDLE;
      req <= '0;
      drain <= 1'b0;
      o_bus_en <= 1'b0;
      done_rdy <= 1'b0;
      o_DM_ReadData <= '0;
    end else begin
      // Drained stores were already acknowledged when posted, so they skip DONE
      done_rdy <= state == BUS && i_ack && !drain;
      case (state)
        IDLE: if (start) begin
          req <= next_req;
          drain <= start_drain;
          o_bus_en <= 1'b1;
          state <= BUS;
        end
        BUS: if (i_ack) begin
          o_bus_en <= 1'b0;
          if (!req.wr) o_DM_ReadData <= i_rd_data;
          state <= drain ? IDLE : DONE;
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_arvi_dmem_bridge.sv
// tb_arvi_dmem_bridge: randomized self-checking bench with a memory-model bus slave
module tb_arvi_dmem_bridge;
  logic i_clk = 1'b0, i_rst_n = 1'b1;
  logic i_DM_MemRead = 1'b0, i_DM_Wen = 1'b0;
  logic [31:0] i_DM_Addr = '0, i_DM_Wd = '0;
  logic [3:0] i_DM_byte_en = '0;
  logic o_DM_data_ready, o_bus_en, o_wr_en;
  logic [31:0] o_DM_ReadData, o_addr, o_wr_data;
  logic [3:0] o_byte_en;
  logic i_ack = 1'b0;
  logic [31:0] i_rd_data = '0;
  int n_tests = 0, n_fail = 0;
  logic [31:0] mem [logic [31:0]];
  logic [31:0] last_rd = '0;
  logic [67:0] wq [$];
`ifdef ARVI_DMEM_WBUF_EN
  localparam bit posted = 1'b1;
`else
  localparam bit posted = 1'b0;
`endif
  always #5 i_clk = ~i_clk;
  arvi_dmem_bridge dut (
    .i_clk           (i_clk),
    .i_rst_n         (i_rst_n),
    .i_DM_MemRead    (i_DM_MemRead),
    .i_DM_Wen        (i_DM_Wen),
    .i_DM_Addr       (i_DM_Addr),
    .i_DM_Wd         (i_DM_Wd),
    .i_DM_byte_en    (i_DM_byte_en),
    .o_DM_data_ready (o_DM_data_ready),
    .o_DM_ReadData   (o_DM_ReadData),
    .o_bus_en        (o_bus_en),
    .o_wr_en         (o_wr_en),
    .o_addr          (o_addr),
    .o_wr_data       (o_wr_data),
    .o_byte_en       (o_byte_en),
    .i_ack           (i_ack),
    .i_rd_data       (i_rd_data)
  );
  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    return mem.exists(a) ? mem[a] : {a[15:0], 16'hC0DE};
  endfunction
  function automatic void mem_wr(input logic [31:0] a, d, input logic [3:0] be);
    logic [31:0] v;
    v = mem_rd(a);
    for (int i = 0; i < 4; i++) if (be[i]) v[8*i +: 8] = d[8*i +: 8];
    mem[a] = v;
  endfunction
  task automatic drive(input logic rd, wr, input logic [31:0] a, d, input logic [3:0] be);
    i_DM_MemRead = rd;
    i_DM_Wen = wr;
    i_DM_Addr = a;
    i_DM_Wd = d;
    i_DM_byte_en = be;
  endtask
  // Full non-posted transaction: request, bus phase with `waits` stall cycles, pulse, idle
  task automatic do_txn(input logic rd, wr, input logic [31:0] a, d, input logic [3:0] be, input int waits, input string nm);
    logic [31:0] rdat;
    drive(rd, wr, a, d, be);
    @(negedge i_clk);
    n_tests++;
    if ({o_bus_en, o_wr_en, o_addr, o_byte_en, o_DM_data_ready} !== {1'b1, wr, a, be, 1'b0}) begin
      n_fail++;
      $display("FAIL %s bus request: got %h want %h", nm, {o_bus_en, o_wr_en, o_addr, o_byte_en, o_DM_data_ready}, {1'b1, wr, a, be, 1'b0});
    end
    if (wr) begin
      n_tests++;
      if (o_wr_data !== d) begin
        n_fail++;
        $display("FAIL %s wr_data: got %h want %h", nm, o_wr_data, d);
      end
    end
    for (int i = 0; i < waits; i++) begin
      @(negedge i_clk);
      n_tests++;
      if ({o_bus_en, o_addr, o_DM_data_ready} !== {1'b1, a, 1'b0}) begin
        n_fail++;
        $display("FAIL %s bus hold: got %h want %h", nm, {o_bus_en, o_addr, o_DM_data_ready}, {1'b1, a, 1'b0});
      end
    end
    rdat = mem_rd(a);
    i_ack = 1'b1;
    i_rd_data = wr ? $urandom : rdat;
    if (wr) mem_wr(a, d, be);
    else last_rd = rdat;
    @(negedge i_clk);
    i_ack = 1'b0;
    i_rd_data = $urandom;
    n_tests++;
    if ({o_DM_data_ready, o_bus_en, o_DM_ReadData} !== {1'b1, 1'b0, last_rd}) begin
      n_fail++;
      $display("FAIL %s completion: got %h want %h", nm, {o_DM_data_ready, o_bus_en, o_DM_ReadData}, {1'b1, 1'b0, last_rd});
    end
    @(negedge i_clk);
    n_tests++;
    if ({o_DM_data_ready, o_bus_en} !== 2'b00) begin
      n_fail++;
      $display("FAIL %s single pulse: got %b want 00", nm, {o_DM_data_ready, o_bus_en});
    end
    drive(1'b0, 1'b0, '0, '0, '0);
  endtask
  task automatic test_reset();
    #1 i_rst_n = 1'b0;
    drive(1'b1, 1'b0, 32'h40, '0, 4'hF);
    repeat (2) @(negedge i_clk);
    n_tests++;
    if ({o_DM_data_ready, o_DM_ReadData, o_bus_en, o_wr_en, o_addr, o_wr_data, o_byte_en} !== '0) begin
      n_fail++;
      $display("FAIL reset outputs: got %h want 0", {o_DM_data_ready, o_DM_ReadData, o_bus_en, o_wr_en, o_addr, o_wr_data, o_byte_en});
    end
    i_rst_n = 1'b1;
    @(negedge i_clk);
    n_tests++;
    if ({o_bus_en, o_wr_en, o_addr} !== {1'b1, 1'b0, 32'h40}) begin
      n_fail++;
      $display("FAIL reset first request: got %h want %h", {o_bus_en, o_wr_en, o_addr}, {1'b1, 1'b0, 32'h40});
    end
    last_rd = mem_rd(32'h40);
    i_ack = 1'b1;
    i_rd_data = last_rd;
    @(negedge i_clk);
    i_ack = 1'b0;
    n_tests++;
    if ({o_DM_data_ready, o_DM_ReadData} !== {1'b1, last_rd}) begin
      n_fail++;
      $display("FAIL reset first load: got %h want %h", {o_DM_data_ready, o_DM_ReadData}, {1'b1, last_rd});
    end
    @(negedge i_clk);
    drive(1'b0, 1'b0, '0, '0, '0);
  endtask
  task automatic test_load();
    mem[32'h100] = 32'hDEADBEEF;
    do_txn(1'b1, 1'b0, 32'h100, '0, 4'hF, 3, "load");
    n_tests++;
    if (o_DM_ReadData !== 32'hDEADBEEF) begin
      n_fail++;
      $display("FAIL load data hold: got %h want deadbeef", o_DM_ReadData);
    end
  endtask
`ifdef ARVI_DMEM_WBUF_EN
  // Posted store: pulse the cycle after capture, then one idle cycle before the next request
  task automatic post_store(input logic [31:0] a, d, input logic [3:0] be, input string nm);
    drive(1'b0, 1'b1, a, d, be);
    @(negedge i_clk);
    n_tests++;
    if (o_DM_data_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL %s posted pulse: got %b want 1", nm, o_DM_data_ready);
    end
    @(negedge i_clk);
    n_tests++;
    if (o_DM_data_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL %s posted single pulse: got %b want 0", nm, o_DM_data_ready);
    end
    drive(1'b0, 1'b0, '0, '0, '0);
    wq.push_back({a, d, be});
  endtask
  task automatic ack_write(input string nm);
    n_tests++;
    if ({o_bus_en, o_wr_en, o_addr, o_wr_data, o_byte_en} !== {2'b11, wq[0]}) begin
      n_fail++;
      $display("FAIL %s drain order: got %h want %h", nm, {o_bus_en, o_wr_en, o_addr, o_wr_data, o_byte_en}, {2'b11, wq[0]});
    end
    mem_wr(wq[0][67:36], wq[0][35:4], wq[0][3:0]);
    void'(wq.pop_front());
    i_ack = 1'b1;
  endtask
  task automatic drain_all(input string nm);
    int budget = 40;
    while (wq.size() > 0 && budget > 0) begin
      @(negedge i_clk);
      budget--;
      if (i_ack) i_ack = 1'b0;
      else if (o_bus_en) ack_write(nm);
    end
    @(negedge i_clk);
    i_ack = 1'b0;
    n_tests++;
    if (wq.size() != 0) begin
      n_fail++;
      $display("FAIL %s drain timeout: got %0d pending want 0", nm, wq.size());
    end
  endtask
  task automatic test_buffered();
    int cnt = 0;
    post_store(32'h500, 32'h11111111, 4'hF, "wbuf s1");
    post_store(32'h504, 32'h22222222, 4'h3, "wbuf s2");
    drive(1'b0, 1'b1, 32'h508, 32'h33333333, 4'hC);
    for (int i = 0; i < 3; i++) begin
      @(negedge i_clk);
      n_tests++;
      if ({o_DM_data_ready, o_bus_en, o_wr_en, o_addr} !== {3'b011, 32'h500}) begin
        n_fail++;
        $display("FAIL wbuf full stall: got %h want %h", {o_DM_data_ready, o_bus_en, o_wr_en, o_addr}, {3'b011, 32'h500});
      end
    end
    ack_write("wbuf s1");
    do begin
      @(negedge i_clk);
      i_ack = 1'b0;
      cnt++;
    end while (!o_DM_data_ready && cnt < 6);
    n_tests++;
    if (cnt != 2) begin
      n_fail++;
      $display("FAIL wbuf slot freed latency: got %0d want 2", cnt);
    end
    @(negedge i_clk);
    drive(1'b0, 1'b0, '0, '0, '0);
    wq.push_back({32'h508, 32'h33333333, 4'hC});
    drain_all("wbuf");
  endtask
  task automatic test_ordering();
    bit seen = 1'b0;
    post_store(32'h300, 32'hA5A5A5A5, 4'hF, "order store");
    drive(1'b1, 1'b0, 32'h300, '0, 4'hF);
    for (int i = 0; i < 3; i++) begin
      @(negedge i_clk);
      n_tests++;
      if ({o_DM_data_ready, o_bus_en, o_wr_en} !== 3'b011) begin
        n_fail++;
        $display("FAIL order load overtook store: got %b want 011", {o_DM_data_ready, o_bus_en, o_wr_en});
      end
    end
    ack_write("order store");
    for (int i = 0; i < 8 && !seen; i++) begin
      @(negedge i_clk);
      i_ack = 1'b0;
      if (o_bus_en) begin
        seen = 1'b1;
        n_tests++;
        if ({o_wr_en, o_addr} !== {1'b0, 32'h300}) begin
          n_fail++;
          $display("FAIL order load request: got %h want %h", {o_wr_en, o_addr}, {1'b0, 32'h300});
        end
        last_rd = mem_rd(32'h300);
        i_rd_data = last_rd;
        i_ack = 1'b1;
      end
    end
    n_tests++;
    if (!seen) begin
      n_fail++;
      $display("FAIL order load timeout: got no request want one");
    end
    @(negedge i_clk);
    i_ack = 1'b0;
    n_tests++;
    if ({o_DM_data_ready, o_DM_ReadData} !== {1'b1, 32'hA5A5A5A5}) begin
      n_fail++;
      $display("FAIL order load data: got %h want %h", {o_DM_data_ready, o_DM_ReadData}, {1'b1, 32'hA5A5A5A5});
    end
    @(negedge i_clk);
    drive(1'b0, 1'b0, '0, '0, '0);
  endtask
`else
  task automatic test_store();
    do_txn(1'b0, 1'b1, 32'h200, 32'h12345678, 4'h3, 2, "store");
  endtask
  task automatic test_illegal();
    do_txn(1'b1, 1'b1, 32'h240, 32'hCAFEF00D, 4'hF, 1, "both high");
  endtask
`endif
  task automatic test_back_to_back();
    for (int n = 0; n < 4; n++)
      do_txn(~n[0] | posted, n[0] & ~posted, 32'h800 + 32'(n) * 4, $urandom, 4'hF, 0, "back to back");
  endtask
  task automatic test_random();
    for (int n = 0; n < 40; n++) begin
      logic rd, wr;
      wr = posted ? 1'b0 : 1'($urandom_range(0, 1));
      rd = wr ? 1'($urandom_range(0, 1)) : 1'b1;
      do_txn(rd, wr, 32'h1000 + 32'($urandom_range(0, 7)) * 4, $urandom, 4'($urandom_range(1, 15)), $urandom_range(0, 4), "random");
    end
  endtask
  task automatic test_reset_mid();
`ifdef ARVI_DMEM_WBUF_EN
    post_store(32'h600, 32'h66666666, 4'hF, "reset mid store");
`else
    drive(1'b1, 1'b0, 32'h480, '0, 4'hF);
    @(negedge i_clk);
`endif
    n_tests++;
    if (o_bus_en !== 1'b1) begin
      n_fail++;
      $display("FAIL reset mid setup: got bus_en %b want 1", o_bus_en);
    end
    #2 i_rst_n = 1'b0;
    #1;
    n_tests++;
    if ({o_bus_en, o_DM_data_ready} !== 2'b00) begin
      n_fail++;
      $display("FAIL reset mid async drop: got %b want 00", {o_bus_en, o_DM_data_ready});
    end
    drive(1'b0, 1'b0, '0, '0, '0);
    wq.delete();
    @(negedge i_clk);
    i_rst_n = 1'b1;
    @(negedge i_clk);
    n_tests++;
    if ({o_bus_en, o_DM_data_ready} !== 2'b00) begin
      n_fail++;
      $display("FAIL reset mid idle: got %b want 00", {o_bus_en, o_DM_data_ready});
    end
    do_txn(1'b1, 1'b0, 32'h700, '0, 4'hF, 1, "load after reset");
  endtask
  initial begin
    test_reset();
    test_load();
`ifdef ARVI_DMEM_WBUF_EN
    test_buffered();
    test_ordering();
`else
    test_store();
    test_illegal();
`endif
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
